// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter merging p_ninputs val/rdy streams into one stream,
// tagging each message with its source index through a one-entry output buffer.
module round_robin_arbiter #(
    parameter int unsigned p_nbits   = 8,
    parameter int unsigned p_ninputs = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [p_ninputs-1:0]                   istream_val,
    output logic [p_ninputs-1:0]                   istream_rdy,
    input  logic [p_ninputs*p_nbits-1:0]           istream_msg,
    output logic                                   ostream_val,
    input  logic                                   ostream_rdy,
    output logic [$clog2(p_ninputs)+p_nbits-1:0]   ostream_msg
);

    localparam int unsigned IW = $clog2(p_ninputs);
    localparam int unsigned OW = IW + p_nbits;

    logic                r_full;
    logic [OW-1:0]       r_data;
    logic [IW-1:0]       r_ptr;

    logic [p_nbits-1:0]  w_msg [p_ninputs];
    logic                w_gnt_any;
    logic [IW-1:0]       w_gnt_idx;
    logic [IW-1:0]       w_ptr_nxt;
    logic                w_can_accept;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic [p_ninputs-1:0] w_rdy;

    for (genvar gi = 0; gi < p_ninputs; gi++) begin : g_unpack
        assign w_msg[gi] = istream_msg[gi*p_nbits +: p_nbits];
    end

    // Rotating-priority scan: first valid requester starting at r_ptr, wrapping.
    always_comb begin
        logic [IW-1:0] v_idx;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        v_idx     = '0;
        for (int unsigned k = 0; k < p_ninputs; k++) begin
            v_idx = IW'((32'(r_ptr) + k) % p_ninputs);
            if (!w_gnt_any && istream_val[v_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = v_idx;
            end
        end
    end

    always_comb begin
        w_can_accept = ~r_full | ostream_rdy;
        w_rdy        = '0;
        if (w_gnt_any && w_can_accept && !reset) begin
            w_rdy[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        if (w_gnt_idx == IW'(p_ninputs - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_gnt_idx + 1'b1;
        end
    end

    assign w_in_xfer  = |w_rdy;
    assign w_out_xfer = r_full & ostream_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_ptr  <= '0;
        end else if (w_in_xfer) begin
            // Also covers a simultaneous drain: the buffer is overwritten and stays full.
            r_full <= 1'b1;
            r_data <= {w_gnt_idx, w_msg[w_gnt_idx]};
            r_ptr  <= w_ptr_nxt;
        end else if (w_out_xfer) begin
            r_full <= 1'b0;
        end
    end

    assign istream_rdy = w_rdy;
    assign ostream_val = r_full;
    assign ostream_msg = r_data;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed self-checking bench for round_robin_arbiter (p_nbits=8, p_ninputs=4).
module tb_round_robin_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  istream_val;
    logic [3:0]  istream_rdy;
    logic [31:0] istream_msg;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [9:0]  ostream_msg;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [9:0] exp_seq [8] = '{10'h010, 10'h111, 10'h212, 10'h313,
                                10'h010, 10'h111, 10'h212, 10'h313};
    logic [3:0] exp_rdy [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    round_robin_arbiter #(.p_nbits(8), .p_ninputs(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        istream_val = 4'b1111;
        istream_msg = {8'h13, 8'h12, 8'h11, 8'h10};
        ostream_rdy = 1'b1;
        #1;
        check_val("rst_rdy", 32'(istream_rdy), 32'h0);
        step();
        check_val("rst_rdy2", 32'(istream_rdy), 32'h0);
        check_val("rst_oval", 32'(ostream_val), 32'h0);
        check_val("rst_omsg", 32'(ostream_msg), 32'h0);
        step();
        reset       = 1'b0;
        istream_val = 4'b0000;
        #1;
        check_val("post_rst_oval", 32'(ostream_val), 32'h0);
        check_val("post_rst_ptr", 32'(dut.r_ptr), 32'h0);

        // Single requester 2
        istream_val = 4'b0100;
        istream_msg = {8'h13, 8'hA5, 8'h11, 8'h10};
        #1;
        check_val("single_rdy", 32'(istream_rdy), 32'h4);
        step();
        istream_val = 4'b0000;
        check_val("single_oval", 32'(ostream_val), 32'h1);
        check_val("single_omsg", 32'(ostream_msg), 32'h2A5);
        check_val("single_ptr", 32'(dut.r_ptr), 32'h3);
        step();
        check_val("single_drain", 32'(ostream_val), 32'h0);

        // Return pointer to 0, then full-rate rotation
        reset = 1'b1;
        step();
        reset       = 1'b0;
        istream_val = 4'b1111;
        istream_msg = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 8; i++) begin
            #1;
            check_val($sformatf("rot_rdy%0d", i), 32'(istream_rdy), 32'(exp_rdy[i % 4]));
            step();
            check_val($sformatf("rot_oval%0d", i), 32'(ostream_val), 32'h1);
            check_val($sformatf("rot_omsg%0d", i), 32'(ostream_msg), 32'(exp_seq[i]));
        end
        check_val("rot_ptr", 32'(dut.r_ptr), 32'h0);

        // Backpressure with 1AB buffered and ptr=2
        istream_val = 4'b0010;
        istream_msg = {8'hD3, 8'hC2, 8'hAB, 8'hB0};
        step();
        check_val("bp_load", 32'(ostream_msg), 32'h1AB);
        ostream_rdy = 1'b0;
        istream_val = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("bp_rdy%0d", i), 32'(istream_rdy), 32'h0);
            step();
            check_val($sformatf("bp_omsg%0d", i), 32'(ostream_msg), 32'h1AB);
            check_val($sformatf("bp_oval%0d", i), 32'(ostream_val), 32'h1);
            check_val($sformatf("bp_ptr%0d", i), 32'(dut.r_ptr), 32'h2);
        end
        ostream_rdy = 1'b1;
        #1;
        check_val("bp_release_rdy", 32'(istream_rdy), 32'h4);
        step();
        check_val("bp_release_omsg", 32'(ostream_msg), 32'h2C2);
        check_val("bp_release_ptr", 32'(dut.r_ptr), 32'h3);

        // Wrap from ptr=3
        istream_val = 4'b1001;
        #1;
        check_val("wrap_rdy3", 32'(istream_rdy), 32'h8);
        step();
        check_val("wrap_omsg3", 32'(ostream_msg), 32'h3D3);
        check_val("wrap_ptr0", 32'(dut.r_ptr), 32'h0);
        #1;
        check_val("wrap_rdy0", 32'(istream_rdy), 32'h1);
        step();
        check_val("wrap_omsg0", 32'(ostream_msg), 32'h0B0);
        check_val("wrap_ptr1", 32'(dut.r_ptr), 32'h1);

        // Idle after a grant to requester 1
        istream_val = 4'b0010;
        #1;
        check_val("idle_grant", 32'(istream_rdy), 32'h2);
        step();
        check_val("idle_omsg", 32'(ostream_msg), 32'h1AB);
        istream_val = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val($sformatf("idle_rdy%0d", i), 32'(istream_rdy), 32'h0);
            step();
            check_val($sformatf("idle_oval%0d", i), 32'(ostream_val), 32'h0);
            check_val($sformatf("idle_ptr%0d", i), 32'(dut.r_ptr), 32'h2);
        end

        // Reset while full and stalled
        ostream_rdy = 1'b0;
        istream_val = 4'b0100;
        step();
        check_val("rst_mid_full", 32'(ostream_val), 32'h1);
        reset       = 1'b1;
        istream_val = 4'b1111;
        #1;
        check_val("rst_mid_rdy", 32'(istream_rdy), 32'h0);
        step();
        check_val("rst_mid_oval", 32'(ostream_val), 32'h0);
        check_val("rst_mid_omsg", 32'(ostream_msg), 32'h0);
        check_val("rst_mid_ptr", 32'(dut.r_ptr), 32'h0);
        reset       = 1'b0;
        istream_val = 4'b0000;
        ostream_rdy = 1'b1;
        step();
        check_val("rst_mid_after", 32'(ostream_val), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter: p_nbits, default 8, payload width of each input message.
REQ-002 Parameter: p_ninputs, default 4, number of requester streams; SHALL be >= 2; index width IW = $clog2(p_ninputs).
REQ-003 Port: clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: istream_val  input  p_ninputs  per-requester valid.
REQ-006 Port: istream_rdy  output  p_ninputs  per-requester ready.
REQ-007 Port: istream_msg  input  p_ninputs*p_nbits  flattened payloads; requester i occupies bits [i*p_nbits +: p_nbits].
REQ-008 Port: ostream_val  output  1  merged-stream valid.
REQ-009 Port: ostream_rdy  input  1  downstream ready.
REQ-010 Port: ostream_msg  output  IW+p_nbits  {source index, payload}; index in the top IW bits, so a downstream router selects on the MSBs and returns the source.

Function
REQ-011 Transfer on any stream SHALL occur only in a cycle where its val and rdy are both 1 at the rising edge.
REQ-012 State: one-entry output buffer (full flag, IW+p_nbits data register) and an IW-bit priority pointer ptr.
REQ-013 Grant SHALL be combinational: the first i with istream_val[i]=1 scanning ptr, ptr+1, ..., wrapping modulo p_ninputs; no valid input -> no grant.
REQ-014 can_accept = ~full | ostream_rdy; istream_rdy[i] SHALL equal grant[i] & can_accept; at most one istream_rdy bit SHALL be 1 per cycle.
REQ-015 On an input transfer from requester g: buffer data <= {g, istream_msg[g]}, full <= 1, ptr <= (g+1) mod p_ninputs.
REQ-016 On an output transfer with no input transfer in the same cycle: full <= 0; data register holds its value.
REQ-017 Simultaneous output and input transfer: buffer SHALL be overwritten with the new message and full SHALL remain 1 (throughput one message per cycle).
REQ-018 ostream_val SHALL equal full; ostream_msg SHALL equal the data register.
REQ-019 Latency: a message accepted at edge N SHALL appear on ostream at cycle N+1 (one cycle).
REQ-020 full=1 and ostream_rdy=0: all istream_rdy SHALL be 0; ostream_msg and ptr SHALL hold.
REQ-021 No input transfer: ptr SHALL NOT change.
REQ-022 Pointer wrap: grant to p_ninputs-1 SHALL set ptr to 0.
REQ-023 Fairness: with all requesters continuously valid and ostream_rdy=1, grants SHALL rotate 0,1,...,p_ninputs-1,0,...; no requester waits more than p_ninputs-1 grants.
REQ-024 ostream_msg content while ostream_val=0 is don't-care except after reset (REQ-026).

Reset
REQ-025 reset=1 at a rising edge SHALL set full=0, ptr=0, data register=0, regardless of concurrent handshakes.
REQ-026 During and the cycle after reset: ostream_val=0, ostream_msg=0; istream_rdy SHALL be 0 while reset=1.
REQ-027 Reset mid-operation SHALL discard any buffered message; no transfer is reported for the reset cycle.

Verification (p_nbits=8, p_ninputs=4)
REQ-028 Reset, then istream_val=4'b0100, msg[2]=8'hA5, ostream_rdy=1 -> istream_rdy=4'b0100; next cycle ostream_val=1, ostream_msg=10'h2A5; ptr=3.
REQ-029 All four valid, msgs 8'h10,8'h11,8'h12,8'h13, ostream_rdy=1 for 8 cycles -> ostream_msg sequence 10'h010,10'h111,10'h212,10'h313,10'h010,... one per cycle.
REQ-030 Backpressure: buffer holds 10'h1AB, ostream_rdy=0 for 3 cycles with istream_val=4'b1111 -> istream_rdy=0, ostream_msg stays 10'h1AB, ptr stays 2; ostream_rdy=1 -> requester 2 granted same cycle.
REQ-031 Wrap: ptr=3, istream_val=4'b1001 -> grant 3, then ptr=0, next grant 0.
REQ-032 Reset asserted while full=1 and ostream_rdy=0 -> next cycle ostream_val=0, ostream_msg=0, ptr=0; istream_rdy=0 during reset.
REQ-033 Idle: istream_val=0 for 5 cycles after a grant to 1 -> istream_rdy=0, ostream_val drops after drain, ptr stays 2.
